// File: rtl/yadmc_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : yadmc_burst_reader
//  Purpose  : Reads a burst of consecutive words from the read port of a
//             registered-output dual-port RAM. It returns them as a
//             valid/ready stream through a 4-entry FIFO, and marks the
//             final word with out_last.
//  Ports    : sys_clk / sys_rst      - clock, synchronous active-high reset
//             cmd_valid/ready/adr/len - burst request (len = words - 1)
//             ram_adr / ram_do       - RAM read address, RAM data (1-cycle)
//             out_valid/ready/data/last - output word stream
//             busy                   - a burst is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module yadmc_burst_reader #(
  parameter int address_depth = 10,
  parameter int data_width    = 8,
  parameter int len_width     = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [address_depth-1:0] cmd_adr,
  input  logic [len_width-1:0]     cmd_len,
  output logic [address_depth-1:0] ram_adr,
  input  logic [data_width-1:0]    ram_do,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [data_width-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [address_depth-1:0] adr_cnt;
  logic [len_width:0]       remaining;
  logic                     pending;       // a read was issued last cycle
  logic                     pending_last;  // ... and it was the burst's final read
  logic [data_width-1:0]    fifo_data [0:3];
  logic [3:0]               fifo_last;
  logic [1:0]               wr_ptr, rd_ptr;
  logic [2:0]               fifo_count, fifo_count_next;

  logic accept, issue, issue_last, push, pop;

  assign accept     = cmd_valid && (state == IDLE);
  // Occupancy plus the in-flight read is capped at 4, so a push never
  // finds the FIFO full.
  assign issue      = (state == READ) && (remaining != '0) &&
                      ((fifo_count + {2'b00, pending}) < 3'd4);
  assign issue_last = issue && (remaining == (len_width+1)'(1));
  assign push       = pending;
  assign pop        = (fifo_count != 3'd0) && out_ready;

  always_comb begin
    fifo_count_next = fifo_count;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count + 3'd1;
      2'b01:   fifo_count_next = fifo_count - 3'd1;
      default: fifo_count_next = fifo_count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    if (issue_last) state_next = DRAIN;
      // A pending read always pushes, so a zero next count also means
      // nothing is in flight.
      DRAIN:   if (fifo_count_next == 3'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      adr_cnt      <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      fifo_count   <= 3'd0;
    end else begin
      if (accept) begin
        adr_cnt   <= cmd_adr;
        remaining <= {1'b0, cmd_len} + (len_width+1)'(1);
      end else if (issue) begin
        adr_cnt   <= adr_cnt + address_depth'(1);
        remaining <= remaining - (len_width+1)'(1);
      end
      pending      <= issue;
      pending_last <= issue_last;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count_next;
    end
  end

  // FIFO storage needs no reset; the read side is gated by the occupancy.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && push) begin
      fifo_data[wr_ptr] <= ram_do;
      fifo_last[wr_ptr] <= pending_last;
    end
  end

  assign ram_adr   = adr_cnt;
  assign out_valid = (fifo_count != 3'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_yadmc_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yadmc_burst_reader
//  Purpose  : Directed bench for yadmc_burst_reader. A table of bursts is
//             followed by hand-written sequences for the mid-burst reset and
//             for a request held across a burst.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_yadmc_burst_reader;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_adr = '0;
  logic [7:0] cmd_len = '0;
  logic [9:0] ram_adr;
  logic [7:0] ram_do = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:1023];
  logic [9:0] radr_log [0:3];

  always #5 sys_clk = ~sys_clk;

  // Registered-output RAM read port
  always @(posedge sys_clk) ram_do <= mem[ram_adr];

  yadmc_burst_reader dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_adr  (cmd_adr),
    .cmd_len  (cmd_len),
    .ram_adr  (ram_adr),
    .ram_do   (ram_do),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  typedef struct {
    logic [9:0] adr;
    logic [7:0] len;
    int         mode;       // 0: out_ready always 1, 1: toggling + 10-cycle stall
    logic [7:0] exp_first;
    logic [7:0] exp_lastw;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after acceptance.
  task automatic send_cmd(input logic [9:0] a, input logic [7:0] l);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_adr   = a;
    cmd_len   = l;
    while (!cmd_ready && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 100) chk("cmd_accept_timeout", 0, 1);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_burst(input logic [9:0] a, input logic [7:0] l, input int mode,
                          input logic [7:0] ef, input logic [7:0] el);
    int k = 0, n = 1, first_n = -1, last_n = -1, maxocc = 0;
    logic       r;
    logic [9:0] ea;
    send_cmd(a, l);
    while (k <= int'(l) && n < 400) begin
      if (n <= 4) radr_log[n-1] = ram_adr;
      if (first_n < 0 && out_valid) first_n = n;
      if (int'(dut.fifo_count) > maxocc) maxocc = int'(dut.fifo_count);
      if (mode == 0)                r = 1'b1;
      else if (n >= 6 && n < 16)    r = 1'b0;
      else                          r = (n % 2) == 1;
      out_ready = r;
      if (out_valid && r) begin
        ea = a + 10'(k);
        chk("word_data_last", {23'd0, out_last, out_data}, {23'd0, (k == int'(l)), ea[7:0]});
        if (k == 0)        chk("first_word", {24'd0, out_data}, {24'd0, ef});
        if (k == int'(l))  chk("last_word", {24'd0, out_data}, {24'd0, el});
        last_n = n;
        k++;
      end
      @(negedge sys_clk);
      n++;
    end
    out_ready = 1'b0;
    chk("burst_word_count", k, int'(l) + 1);
    chk("idle_after_burst", {29'd0, busy, cmd_ready, out_valid}, {29'd0, 3'b010});
    if (mode == 0) begin
      chk("first_latency", first_n, 3);
      chk("no_bubbles", last_n - first_n, int'(l));
    end else begin
      chk("max_occupancy", (maxocc <= 4), 1);
    end
  endtask

  initial begin
    int k, n, early, nz;
    logic drop;
    logic [7:0] ex [7];
    logic       exl [7];

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    tbl[0] = '{10'h010, 8'd3,  0, 8'h10, 8'h13};
    tbl[1] = '{10'h3FE, 8'd3,  0, 8'hFE, 8'h01};
    tbl[2] = '{10'h100, 8'd15, 1, 8'h00, 8'h0F};
    tbl[3] = '{10'h055, 8'd0,  0, 8'h55, 8'h55};
    tbl[4] = '{10'h3F0, 8'd31, 0, 8'hF0, 8'h0F};

    // Reset state
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_ram_adr",   ram_adr, 0);
    chk("rst_out_data",  out_data, 0);

    for (int i = 0; i < 5; i++) begin
      do_burst(tbl[i].adr, tbl[i].len, tbl[i].mode, tbl[i].exp_first, tbl[i].exp_lastw);
      if (i == 1) begin
        chk("wrap_adr0", radr_log[0], 10'h3FE);
        chk("wrap_adr1", radr_log[1], 10'h3FF);
        chk("wrap_adr2", radr_log[2], 10'h000);
        chk("wrap_adr3", radr_log[3], 10'h001);
      end
    end

    // Reset after 3 of 8 words, with a coincident request
    send_cmd(10'h200, 8'd7);
    k = 0;
    n = 0;
    while (k < 3 && n < 100) begin
      out_ready = 1'b1;
      if (out_valid) k++;
      @(negedge sys_clk);
      n++;
    end
    chk("pre_reset_words", k, 3);
    sys_rst   = 1'b1;
    out_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_adr   = 10'h155;
    cmd_len   = 8'd5;
    @(negedge sys_clk);
    sys_rst   = 1'b0;
    cmd_valid = 1'b0;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy",      busy, 0);
    chk("mrst_cmd_ready", cmd_ready, 1);
    chk("mrst_ram_adr",   ram_adr, 0);
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (out_valid || busy) nz++;
    end
    chk("mrst_stays_empty", nz, 0);
    do_burst(10'h020, 8'd1, 0, 8'h20, 8'h21);

    // Request held across a burst
    ex  = '{8'h80, 8'h81, 8'h82, 8'h83, 8'hC0, 8'hC1, 8'hC2};
    exl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    cmd_valid = 1'b1;
    cmd_adr   = 10'h080;
    cmd_len   = 8'd3;
    @(negedge sys_clk);
    cmd_adr = 10'h0C0;
    cmd_len = 8'd2;
    k = 0;
    n = 0;
    early = 0;
    drop = 1'b0;
    while (k < 7 && n < 200) begin
      if (drop) cmd_valid = 1'b0;
      out_ready = 1'b1;
      if (k < 4 && cmd_ready) early++;
      if (k == 4 && cmd_ready && cmd_valid) drop = 1'b1;
      if (out_valid) begin
        chk("held_req_word", {23'd0, out_last, out_data}, {23'd0, exl[k], ex[k]});
        k++;
      end
      @(negedge sys_clk);
      n++;
    end
    out_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("held_req_count", k, 7);
    chk("held_req_early_accept", early, 0);
    chk("held_req_idle", {30'd0, busy, cmd_ready}, {30'd0, 2'b01});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
